// File: rtl/ikaopll_pkg.sv
// rtl/ikaopll_pkg.sv - shared IKAOPLL bus-writer state encoding and timing defaults
package ikaopll_pkg;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_A_SETUP  = 4'd1;
   localparam logic [3:0] ST_A_STROBE = 4'd2;
   localparam logic [3:0] ST_A_HOLD   = 4'd3;
   localparam logic [3:0] ST_A_WAIT   = 4'd4;
   localparam logic [3:0] ST_D_SETUP  = 4'd5;
   localparam logic [3:0] ST_D_STROBE = 4'd6;
   localparam logic [3:0] ST_D_HOLD   = 4'd7;
   localparam logic [3:0] ST_D_WAIT   = 4'd8;

   localparam int OPLL_SETUP_LEN = 1;
   localparam int OPLL_PULSE_LEN = 2;
   localparam int OPLL_ADDR_WAIT = 12;
   localparam int OPLL_DATA_WAIT = 84;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ikaopll_bus_timer.sv
// rtl/ikaopll_bus_timer.sv - loadable CEN-qualified down-counter with zero flag
module ikaopll_bus_timer #(
   parameter int W = 8
) (
   input  logic         i_EMUCLK,
   input  logic         i_RST,
   input  logic         i_CEN_n,
   input  logic         i_LOAD,
   input  logic [W-1:0] i_LOAD_VAL,
   output logic         o_ZERO
);

   logic [W-1:0] r_cnt;

   // Load wins over counting so a request accepted on a non-CEN edge still arms the timer.
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST)
         r_cnt <= '0;
      else if (i_LOAD)
         r_cnt <= i_LOAD_VAL;
      else if (!i_CEN_n && r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   end

   assign o_ZERO = (r_cnt == '0);

endmodule

// File: rtl/ikaopll_bus_writer.sv
// rtl/ikaopll_bus_writer.sv - turns one (addr, data) request into the two-phase YM2413 bus write
module ikaopll_bus_writer
   import ikaopll_pkg::*;
#(
   parameter int SETUP_LEN = OPLL_SETUP_LEN,
   parameter int PULSE_LEN = OPLL_PULSE_LEN,
   parameter int ADDR_WAIT = OPLL_ADDR_WAIT,
   parameter int DATA_WAIT = OPLL_DATA_WAIT
) (
   input  logic       i_EMUCLK,
   input  logic       i_RST,
   input  logic       i_CEN_n,
   input  logic       i_REQ,
   input  logic [7:0] i_ADDR,
   input  logic [7:0] i_DATA,
   output logic       o_READY,
   output logic       o_DONE,
   output logic       o_CS_n,
   output logic       o_WR_n,
   output logic       o_A0,
   output logic [7:0] o_D
);

   localparam int CNT_W = $clog2(max_of4(SETUP_LEN, PULSE_LEN, ADDR_WAIT, DATA_WAIT)) + 1;

   logic [3:0]       r_state;
   logic [7:0]       r_data;
   logic             r_ready, r_done, r_cs_n, r_wr_n, r_a0;
   logic [7:0]       r_d;

   logic             w_zero, w_accept, w_adv, w_load;
   logic [3:0]       w_next;
   logic [CNT_W-1:0] w_next_len, w_load_val;

   assign w_accept = i_REQ && r_ready;
   assign w_adv    = !i_CEN_n && (r_state != ST_IDLE) && w_zero;
   assign w_load   = w_accept || w_adv;
   assign w_next   = (r_state == ST_D_WAIT) ? ST_IDLE : r_state + 4'd1;

   always_comb begin
      w_next_len = '0;
      case (w_next)
         ST_A_SETUP, ST_D_SETUP:   w_next_len = CNT_W'(SETUP_LEN - 1);
         ST_A_STROBE, ST_D_STROBE: w_next_len = CNT_W'(PULSE_LEN - 1);
         ST_A_WAIT:                w_next_len = CNT_W'(ADDR_WAIT - 1);
         ST_D_WAIT:                w_next_len = CNT_W'(DATA_WAIT - 1);
         default:                  w_next_len = '0;
      endcase
      w_load_val = w_accept ? CNT_W'(SETUP_LEN - 1) : w_next_len;
   end

   ikaopll_bus_timer #(.W(CNT_W)) u_timer (
      .i_EMUCLK   (i_EMUCLK),
      .i_RST      (i_RST),
      .i_CEN_n    (i_CEN_n),
      .i_LOAD     (w_load),
      .i_LOAD_VAL (w_load_val),
      .o_ZERO     (w_zero)
   );

   // Each bus pin is updated only on the transition into the state that owns it.
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         r_state <= ST_IDLE;
         r_data  <= 8'h00;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_a0    <= 1'b0;
         r_d     <= 8'h00;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_state <= ST_A_SETUP;
            r_data  <= i_DATA;
            r_ready <= 1'b0;
            r_cs_n  <= 1'b0;
            r_wr_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_d     <= i_ADDR;
         end else if (w_adv) begin
            r_state <= w_next;
            case (w_next)
               ST_A_STROBE, ST_D_STROBE: r_wr_n <= 1'b0;
               ST_A_HOLD, ST_D_HOLD:     r_wr_n <= 1'b1;
               ST_A_WAIT, ST_D_WAIT:     r_cs_n <= 1'b1;
               ST_D_SETUP: begin
                  r_cs_n <= 1'b0;
                  r_a0   <= 1'b1;
                  r_d    <= r_data;
               end
               ST_IDLE: begin
                  r_ready <= 1'b1;
                  r_done  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_READY = r_ready;
   assign o_DONE  = r_done;
   assign o_CS_n  = r_cs_n;
   assign o_WR_n  = r_wr_n;
   assign o_A0    = r_a0;
   assign o_D     = r_d;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// tb/tb_ikaopll_bus_writer.sv - self-checking bench for ikaopll_bus_writer against a timeline model
module tb_ikaopll_bus_writer;

   localparam int S     = 1;
   localparam int P     = 2;
   localparam int AW    = 12;
   localparam int DW    = 84;
   localparam int PH    = S + P + 1 + AW;
   localparam int TOTAL = 2 * (S + P + 1) + AW + DW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen_n = 1'b0;
   logic       req = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] data = 8'h00;
   logic       ready, done, cs_n, wr_n, a0;
   logic [7:0] d;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int cen_per = 1;
   int cen_edges = 0;

   // Model: position in the write timeline, counted in CEN edges since acceptance.
   bit         m_busy = 1'b0;
   int         m_k = 0;
   int         m_acc = 0;
   logic [7:0] m_addr = 8'h00, m_data = 8'h00, m_idle_d = 8'h00;
   logic       m_idle_a0 = 1'b0, m_done = 1'b0;

   logic prev_wr = 1'b1;
   int   fall_q[$];

   always #5 clk = ~clk;

   ikaopll_bus_writer #(
      .SETUP_LEN(S), .PULSE_LEN(P), .ADDR_WAIT(AW), .DATA_WAIT(DW)
   ) dut (
      .i_EMUCLK (clk),
      .i_RST    (rst),
      .i_CEN_n  (cen_n),
      .i_REQ    (req),
      .i_ADDR   (addr),
      .i_DATA   (data),
      .o_READY  (ready),
      .o_DONE   (done),
      .o_CS_n   (cs_n),
      .o_WR_n   (wr_n),
      .o_A0     (a0),
      .o_D      (d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_busy = 1'b0; m_k = 0; m_done = 1'b0; m_idle_a0 = 1'b0; m_idle_d = 8'h00;
      end else begin
         m_done = 1'b0;
         if (!m_busy && req) begin
            m_busy = 1'b1; m_k = 0; m_addr = addr; m_data = data; m_acc++;
         end else if (m_busy && !cen_n) begin
            m_k++;
            if (m_k == TOTAL) begin
               m_busy = 1'b0; m_done = 1'b1; m_idle_a0 = 1'b1; m_idle_d = m_data;
            end
         end
      end
      if (!cen_n) cen_edges++;
   endtask

   task automatic check_outputs();
      logic       e_cs, e_wr, e_a0;
      logic [7:0] e_d;
      int         p;
      if (m_busy) begin
         e_a0 = (m_k >= PH);
         p    = e_a0 ? m_k - PH : m_k;
         e_d  = e_a0 ? m_data : m_addr;
         e_wr = !(p >= S && p < S + P);
         e_cs = !(p <= S + P);
      end else begin
         e_cs = 1'b1; e_wr = 1'b1; e_a0 = m_idle_a0; e_d = m_idle_d;
      end
      chk("cs_n", cs_n, e_cs);
      chk("wr_n", wr_n, e_wr);
      chk("a0", a0, e_a0);
      chk("d", d, e_d);
      chk("ready", ready, !m_busy);
      chk("done", done, m_done);
      if (prev_wr === 1'b1 && wr_n === 1'b0) fall_q.push_back(cen_edges);
      prev_wr = wr_n;
   endtask

   task automatic step();
      cen_n = !((cyc % cen_per) == 0);
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_ready(output int lat, output int dn);
      lat = 0; dn = 0;
      while (ready !== 1'b1 && lat < 3000) begin
         step();
         lat++;
         if (done === 1'b1) dn++;
      end
      chk("ready_timeout", ready, 1'b1);
   endtask

   initial begin
      int lat, dn, acc0, rk;

      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (20) step();
      rst = 1'b1; step(); rst = 1'b0;
      repeat (5) step();

      addr = 8'h10; data = 8'h5A; req = 1'b1; step();
      req = 1'b0; addr = 8'($urandom); data = 8'($urandom);
      wait_ready(lat, dn);
      chk("latency_cen1", lat, 104);
      chk("done_count_cen1", dn, 1);
      repeat (3) step();

      cen_per = 4;
      while ((cyc % 4) != 0) step();
      addr = 8'h10; data = 8'h5A; req = 1'b1; step();
      req = 1'b0;
      wait_ready(lat, dn);
      chk("latency_cen4", lat, 416);
      chk("done_count_cen4", dn, 1);
      repeat (5) step();

      cen_per = 1;
      fall_q.delete();
      acc0 = m_acc;
      addr = 8'h10; data = 8'h5A; req = 1'b1; step();
      addr = 8'h20; data = 8'($urandom);
      for (int i = 0; i < 1000 && m_acc < acc0 + 2; i++) step();
      req = 1'b0;
      wait_ready(lat, dn);
      chk("b2b_fall_count", fall_q.size(), 4);
      if (fall_q.size() >= 4) begin
         chk("b2b_gap_a2d", (fall_q[1] - fall_q[0]) >= 16, 1);
         chk("b2b_gap_d2a", (fall_q[2] - fall_q[1]) >= 88, 1);
         chk("b2b_gap_a2d_2", (fall_q[3] - fall_q[2]) >= 16, 1);
      end

      addr = 8'($urandom); data = 8'($urandom); req = 1'b1; step();
      req = 1'b0;
      for (int i = 0; i < 500 && !(m_busy && m_k == PH + S); i++) step();
      chk("reached_d_strobe", wr_n, 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("abort_ready", ready, 1'b1);
      repeat (10) step();
      addr = 8'($urandom); data = 8'($urandom); req = 1'b1; step();
      req = 1'b0;
      wait_ready(lat, dn);
      chk("after_abort_done", dn, 1);

      for (int t = 0; t < 6; t++) begin
         cen_per = int'($urandom_range(1, 3));
         repeat ($urandom_range(0, 4)) step();
         addr = 8'($urandom); data = 8'($urandom); req = 1'b1; step();
         if ($urandom_range(0, 1) == 1) begin
            addr = 8'($urandom); data = 8'($urandom);
            repeat ($urandom_range(1, 6)) step();
         end
         req = 1'b0;
         if (t == 3) begin
            rk = int'($urandom_range(1, TOTAL - 1));
            for (int i = 0; i < 1000 && m_busy && m_k < rk; i++) step();
            rst = 1'b1; step(); rst = 1'b0;
         end
         wait_ready(lat, dn);
      end
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
